// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, cyclically.
module mul_rr_pick
    import mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_onehot_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            any_o
);

    // Scan from the farthest offset back to ptr so the nearest valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx       = (int'(ptr_i) + k) % NREQ;
            gnt_idx_o = req_valid_i[idx] ? IDW'(idx) : gnt_idx_o;
            any_o     = any_o | req_valid_i[idx];
        end
        gnt_onehot_o = any_o ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_o) : {NREQ{1'b0}};
    end

endmodule

// File: rtl/rca_array_mul.sv
// Combinational unsigned array multiplier built from ripple-carry adder rows.
module rca_array_mul #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);

    // Accumulate one shifted partial product per row through a ripple-carry chain.
    always_comb begin
        logic [2*WIDTH-1:0] acc_s;
        logic [2*WIDTH-1:0] pp_s;
        logic               carry_s;
        logic               sum_s;
        acc_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp_s    = b_i[i] ? ({{WIDTH{1'b0}}, a_i} << i) : {(2*WIDTH){1'b0}};
            carry_s = 1'b0;
            for (int j = 0; j < 2*WIDTH; j++) begin
                sum_s    = acc_s[j] ^ pp_s[j] ^ carry_s;
                carry_s  = (acc_s[j] & pp_s[j]) | (carry_s & (acc_s[j] ^ pp_s[j]));
                acc_s[j] = sum_s;
            end
        end
        p_o = acc_s;
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sequencer sharing one array multiplier among NREQ requesters,
// with a fully registered valid/ready response port.
module mul_share_arb
    import mul_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_s
);

    state_e             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     ptr_d;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [IDW-1:0]     id_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [2*WIDTH-1:0] rsp_s_q;

    logic [NREQ-1:0]    gnt_onehot_s;
    logic [IDW-1:0]     gnt_idx_s;
    logic               any_s;
    logic [2*WIDTH-1:0] prod_s;

    mul_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid_i  (req_valid),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (gnt_onehot_s),
        .gnt_idx_o    (gnt_idx_s),
        .any_o        (any_s)
    );

    rca_array_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (prod_s)
    );

    assign ptr_d = (gnt_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_idx_s + IDW'(1);

    // Ready is gated by reset so nothing appears accepted while the block is held.
    assign req_ready = (rst_n && (state_q == IDLE)) ? gnt_onehot_s : {NREQ{1'b0}};

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;

    // Transaction FSM: accept in IDLE, register product in CALC, hold response in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_s) begin
                        op_a_q  <= req_a[int'(gnt_idx_s)*WIDTH +: WIDTH];
                        op_b_q  <= req_b[int'(gnt_idx_s)*WIDTH +: WIDTH];
                        id_q    <= gnt_idx_s;
                        ptr_q   <= ptr_d;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rsp_s_q     <= prod_s;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed, table-driven bench for mul_share_arb with hand-computed expectations.
module tb_mul_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] s;
    } vec_t;

    vec_t vecs [8];

    mul_share_arb #(.WIDTH(4), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    // One full transaction: operands on the expected lane, decoys on the others.
    task automatic do_txn(input vec_t v);
        logic [3:0] oh;
        oh = 4'b0001 << v.id;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) set_lane(i, ~v.a, ~v.b);
        set_lane(int'(v.id), v.a, v.b);
        req_valid = v.mask;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("grant", {28'd0, req_ready}, {28'd0, oh});
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("calc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_id", {30'd0, rsp_id}, {30'd0, v.id});
        check("rsp_s", {24'd0, rsp_s}, {24'd0, v.s});
        @(negedge clk);
        check("rsp_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] hold_s;
        vecs[0] = '{4'b0001, 2'd0, 4'd13, 4'd14, 8'd182};
        vecs[1] = '{4'b0100, 2'd2, 4'd0,  4'd15, 8'd0};
        vecs[2] = '{4'b0010, 2'd1, 4'd15, 4'd15, 8'hE1};
        vecs[3] = '{4'b1111, 2'd2, 4'd7,  4'd9,  8'd63};
        vecs[4] = '{4'b1111, 2'd3, 4'd15, 4'd1,  8'd15};
        vecs[5] = '{4'b1010, 2'd1, 4'd8,  4'd8,  8'd64};
        vecs[6] = '{4'b1001, 2'd3, 4'd15, 4'd15, 8'd225};
        vecs[7] = '{4'b1111, 2'd0, 4'd0,  4'd0,  8'd0};

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_ready", {28'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
        check("reset_rsp_s", {24'd0, rsp_s}, 32'd0);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) do_txn(vecs[t]);

        // All requesters valid continuously: grants rotate, one result every 3 cycles.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 1), 4'd15);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rot_grant", {28'd0, req_ready}, {28'd0, 4'b0001 << (k % 4)});
            check("rot_idle_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            check("rot_calc_ready", {28'd0, req_ready}, 32'd0);
            @(negedge clk);
            check("rot_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("rot_rsp_id", {30'd0, rsp_id}, (k % 4));
            check("rot_rsp_s", {24'd0, rsp_s}, 15 * ((k % 4) + 1));
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;

        // Backpressure: response held for 5 cycles while every requester waits.
        @(posedge clk); #1;
        set_lane(2, 4'd5, 4'd6);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_grant", {28'd0, req_ready}, 32'h4);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_rsp_s", {24'd0, rsp_s}, 32'd30);
        hold_s = rsp_s;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_hold_s", {24'd0, rsp_s}, 32'd30);
            check("bp_hold_id", {30'd0, rsp_id}, 32'd2);
            check("bp_ready_zero", {28'd0, req_ready}, 32'd0);
        end
        check("bp_stable", {24'd0, rsp_s}, {24'd0, hold_s});
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", {31'd0, rsp_valid}, 32'd0);
        check("bp_next_grant", {28'd0, req_ready}, 32'h8);
        req_valid = 4'b0000;

        // Reset while in CALC drops the transaction and returns ptr to 0.
        @(posedge clk); #1;
        set_lane(3, 4'd9, 4'd9);
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        @(negedge clk);
        check("mid_reset_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_txn('{4'b1111, 2'd0, 4'd2, 4'd3, 8'd6});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one combinational `rca_array_mul` among `NREQ` requesters. It accepts one operand pair at a time over per-requester valid/ready, registers the operands and drives the shared multiplier. It then registers the product and returns it with the winning requester's ID over a single valid/ready response port. It sits between multiplier clients (e.g. MAC/divider sequencers) and the array multiplier.

## Interface
- `WIDTH`, 4: operand width, passed to `rca_array_mul`; product is `2*WIDTH`.
- `NREQ`, 4: number of requesters, must be at least 2.
- `IDW`, `$clog2(NREQ)`: requester ID width (derived; not overridden).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in `NREQ`: bit i set means requester i presents an operand pair.
- `req_ready` out `NREQ`: one-hot or zero; bit i set means pair i is accepted this cycle.
- `req_a` in `NREQ*WIDTH`: operand A of requester i, at bits `[i*WIDTH +: WIDTH]`.
- `req_b` in `NREQ*WIDTH`: operand B of requester i, at the same slicing.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out `IDW`: index of the requester that owns `rsp_s`.
- `rsp_s` out `2*WIDTH`: unsigned product `A*B`.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - `req_ready` is one-hot on the granted index whenever any `req_valid` is set; otherwise it is zero.
  - Grant goes to the first set `req_valid` at or after `ptr`, searching cyclically modulo `NREQ`.
  - On accept (`req_valid[g] & req_ready[g]`): capture `req_a[g]` and `req_b[g]` into `op_a`/`op_b` and `g` into `id_q`; set `ptr <= (g+1) mod NREQ`; go to CALC.
- CALC:
  - `req_ready` = 0.
  - `op_a`/`op_b` drive the shared `rca_array_mul`.
  - At the clock edge, the multiplier output is registered into `rsp_s`, `rsp_id <= id_q`, `rsp_valid <= 1`; go to RESP.
- RESP:
  - `req_ready` = 0.
  - `rsp_valid`, `rsp_id` and `rsp_s` hold stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`: `rsp_valid <= 0`, go to IDLE. A new request is not accepted in the same cycle.
- Arithmetic: unsigned only, full `2*WIDTH` product, no truncation or saturation.
- `ptr` advances only on accept. It wraps from `NREQ-1` to 0.
- Requesters must hold `req_valid` and operands until their `req_ready` is seen. A requester that drops `req_valid` before grant is skipped, with no error.
- Unused/idle `rsp_s` and `rsp_id` retain their last values. They are meaningful only while `rsp_valid` = 1.

## Timing
- Reset (`rst_n` = 0 sampled at an edge):
  - State IDLE; `ptr` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_s` = 0; operand and ID registers = 0.
  - `req_ready` = 0 while `rst_n` is low.
- Reset mid-operation (in CALC or RESP) discards the in-flight transaction. No response is issued for it.
- Latency: accept at edge E0 gives `rsp_valid` = 1 after edge E1 (the edge closing CALC). With `rsp_ready` held high, the handshake completes at E2.
- Throughput: at most one transaction per 3 cycles.
- `req_ready` depends combinationally on `req_valid` and `ptr`. It does not depend on `rsp_ready`.
- The response path is fully registered. `rsp_*` have no combinational path from any input.
- If all requesters are valid continuously, grants rotate 0,1,2,3,0,… There is no starvation: worst-case wait is `NREQ-1` transactions.

## Structure
- Shared package `mul_pkg`: FSM state enum (`IDLE`/`CALC`/`RESP`) and an ID-width helper function (clog2 with minimum 1).
- Sub-module `mul_rr_pick`: combinational round-robin picker. Inputs are `req_valid` and `ptr`; outputs are `gnt_onehot`, `gnt_idx` and `any`.
- Instantiates the existing `rca_array_mul` with `.WIDTH(WIDTH)` on `op_a`/`op_b`.

## Test plan
- Single request: requester 0 sends A=13, B=14, `rsp_ready` = 1. Expect `req_ready[0]` in the accept cycle, `rsp_valid` 2 cycles later, `rsp_s` = 182, `rsp_id` = 0.
- All 4 valid continuously, after reset. Operands A=i+1, B=15. Expect grants in order 0,1,2,3,0 with `rsp_s` = 15, 30, 45, 60, and one result every 3 cycles.
- Backpressure: `rsp_ready` = 0 for 5 cycles after `rsp_valid`. Expect `rsp_*` stable, all `req_ready` = 0, no new grant until the handshake.
- Wrap/skip: `ptr` = 3 and only requester 1 valid (A=15, B=15). Expect grant 1, `rsp_s` = 225, then `ptr` = 2.
- Reset mid-op: deassert `rst_n` for 1 cycle in CALC. Expect `rsp_valid` = 0, `ptr` = 0, no response for the dropped transaction. Then the next request (A=2, B=3) returns 6.
- Extremes: A=0, B=15 gives 0; A=15, B=15 gives 225 (`rsp_s` = 8'hE1), with correct `rsp_id`.
